// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: direct-mapped cache of 16-bit instructions, filled
// byte-by-byte from program memory over a req/ack handshake.
module inst_fetch_unit #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc,
    input  logic        pc_valid,
    input  logic        flush,
    output logic [15:0] inst,
    output logic        inst_valid,
    output logic        misalign,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack
);

    localparam int unsigned TAG_W = 15 - IDX_W;

    typedef enum logic [1:0] {IDLE, FETCH_LO, FETCH_HI} state_t;

    state_t state, state_next;

    logic [DEPTH-1:0] line_valid, line_valid_next;
    logic [15:0]      line_data [DEPTH];
    logic [TAG_W-1:0] line_tag  [DEPTH];

    logic [15:0] fpc, fpc_next;
    logic [7:0]  lo, lo_next;
    logic        flush_pend, flush_pend_next;

    logic [15:0] inst_next;
    logic        inst_valid_next;
    logic        misalign_next;
    logic        mem_rd_next;
    logic [15:0] mem_addr_next;

    logic             fill_we;
    logic [15:0]      fill_data;
    logic [IDX_W-1:0] pc_idx, fpc_idx;
    logic [TAG_W-1:0] pc_tag, fpc_tag;
    logic             hit;
    logic             acked;

    assign pc_idx    = pc[IDX_W:1];
    assign pc_tag    = pc[15:IDX_W+1];
    assign fpc_idx   = fpc[IDX_W:1];
    assign fpc_tag   = fpc[15:IDX_W+1];
    assign hit       = line_valid[pc_idx] && (line_tag[pc_idx] == pc_tag);
    assign acked     = mem_rd && mem_ack;
    assign fill_data = {mem_rdata, lo};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        line_valid_next = line_valid;
        fpc_next        = fpc;
        lo_next         = lo;
        flush_pend_next = flush_pend;
        inst_next       = inst;
        inst_valid_next = 1'b0;
        misalign_next   = 1'b0;
        mem_rd_next     = mem_rd;
        mem_addr_next   = mem_addr;
        fill_we         = 1'b0;

        case (state)
            IDLE: begin
                if (pc_valid) begin
                    if (pc[0]) begin
                        misalign_next = 1'b1;
                    end else if (hit && !flush) begin
                        inst_next       = line_data[pc_idx];
                        inst_valid_next = 1'b1;
                    end else begin
                        fpc_next      = pc;
                        mem_addr_next = pc;
                        mem_rd_next   = 1'b1;
                        state_next    = FETCH_LO;
                    end
                end
                if (flush) begin
                    line_valid_next = '0;
                end
            end
            FETCH_LO: begin
                if (flush) begin
                    flush_pend_next = 1'b1;
                end
                if (acked) begin
                    lo_next       = mem_rdata;
                    mem_addr_next = fpc + 16'd1;
                    state_next    = FETCH_HI;
                end
            end
            FETCH_HI: begin
                if (flush) begin
                    flush_pend_next = 1'b1;
                end
                if (acked) begin
                    mem_rd_next = 1'b0;
                    state_next  = IDLE;
                    // A flush seen at any point in the fill discards the fetched line.
                    if (flush_pend || flush) begin
                        line_valid_next = '0;
                        flush_pend_next = 1'b0;
                    end else begin
                        fill_we                  = 1'b1;
                        line_valid_next[fpc_idx] = 1'b1;
                        if (pc_valid && (pc == fpc)) begin
                            inst_next       = fill_data;
                            inst_valid_next = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_valid <= '0;
            fpc        <= '0;
            lo         <= '0;
            flush_pend <= 1'b0;
            inst       <= '0;
            inst_valid <= 1'b0;
            misalign   <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
        end else begin
            line_valid <= line_valid_next;
            fpc        <= fpc_next;
            lo         <= lo_next;
            flush_pend <= flush_pend_next;
            inst       <= inst_next;
            inst_valid <= inst_valid_next;
            misalign   <= misalign_next;
            mem_rd     <= mem_rd_next;
            mem_addr   <= mem_addr_next;
        end
    end

    // Line storage needs no reset; the valid bits gate every read.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            line_data[fpc_idx] <= fill_data;
            line_tag[fpc_idx]  <= fpc_tag;
        end
    end

endmodule
